pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline stage register that generalises the fixed per-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block.
- Carries a packed DATA_W payload with a valid/ready elastic handshake.
- Supports synchronous flush for branch/exception squash.
- Has an optional 2-entry skid buffer so in_ready is a pure register output.
- Includes a saturating bubble counter for pipeline performance measurement.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with optional 2-entry skid buffer, synchronous flush
// and a saturating bubble counter for pipeline stall/idle measurement.
module pipe_stage_skid #(
    parameter int             DATA_W    = 32,
    parameter int             SKID      = 1,
    parameter logic [255:0]   RESET_VAL = '0,
    parameter int             CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              bubble_clr
);

    localparam logic [DATA_W-1:0] RST_DATA = RESET_VAL[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_inReady;
    logic [CNT_W-1:0]  r_bubble;

    logic w_inXfer;
    logic w_outXfer;
    logic w_bubble;

    // Flush masks in_ready in both modes so upstream never sees a squashed payload as taken.
    assign out_valid  = (r_occ != EMPTY);
    assign in_ready   = ~flush & ((SKID != 0) ? r_inReady : (~out_valid | out_ready));
    assign out_data   = r_main;
    assign occupancy  = r_occ;
    assign bubble_cnt = r_bubble;

    assign w_inXfer  = in_valid & in_ready;
    assign w_outXfer = out_valid & out_ready;
    assign w_bubble  = out_ready & ~out_valid & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ     <= EMPTY;
            r_main    <= RST_DATA;
            r_skid    <= RST_DATA;
            r_inReady <= 1'b1;
        end else if (flush) begin
            r_occ     <= EMPTY;
            r_main    <= RST_DATA;
            r_skid    <= RST_DATA;
            r_inReady <= 1'b1;
        end else if (SKID != 0) begin
            // r_inReady tracks whether the next state still has a free slot.
            case (r_occ)
                EMPTY: begin
                    if (w_inXfer) begin
                        r_main <= in_data;
                        r_occ  <= ONE;
                    end
                end
                ONE: begin
                    if (w_inXfer && w_outXfer) begin
                        r_main <= in_data;
                    end else if (w_inXfer) begin
                        r_skid    <= in_data;
                        r_occ     <= TWO;
                        r_inReady <= 1'b0;
                    end else if (w_outXfer) begin
                        r_occ <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_outXfer) begin
                        r_main    <= r_skid;
                        r_occ     <= ONE;
                        r_inReady <= 1'b1;
                    end
                end
                default: begin
                    r_occ     <= EMPTY;
                    r_inReady <= 1'b1;
                end
            endcase
        end else begin
            if (w_inXfer) begin
                r_main <= in_data;
                r_occ  <= ONE;
            end else if (w_outXfer) begin
                r_occ <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble <= '0;
        end else if (bubble_clr) begin
            r_bubble <= '0;
        end else if (w_bubble && (r_bubble != CNT_MAX)) begin
            r_bubble <= r_bubble + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one SKID=1 instance (4-bit counter, non-zero reset
// value) and one SKID=0 instance share the same stimulus.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;
    logic        bubbleClr;

    logic        s1InReady, s1OutValid;
    logic [31:0] s1OutData;
    logic [1:0]  s1Occ;
    logic [3:0]  s1Bubble;

    logic        s0InReady, s0OutValid;
    logic [31:0] s0OutData;
    logic [1:0]  s0Occ;
    logic [15:0] s0Bubble;

    int checks;
    int errors;

    pipe_stage_skid #(
        .DATA_W(32), .SKID(1), .RESET_VAL(256'hDEADBEEF), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(s1InReady), .in_data(inData),
        .out_valid(s1OutValid), .out_ready(outReady), .out_data(s1OutData),
        .occupancy(s1Occ), .bubble_cnt(s1Bubble), .bubble_clr(bubbleClr)
    );

    pipe_stage_skid #(
        .DATA_W(32), .SKID(0), .RESET_VAL(256'h0), .CNT_W(16)
    ) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(s0InReady), .in_data(inData),
        .out_valid(s0OutValid), .out_ready(outReady), .out_data(s0OutData),
        .occupancy(s0Occ), .bubble_cnt(s0Bubble), .bubble_clr(bubbleClr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (s1OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_s1_valid got %b want 0", s1OutValid); end
        checks++; if (s1Occ !== 2'd0) begin errors++; $display("[TB] FAIL reset_s1_occ got %0d want 0", s1Occ); end
        checks++; if (s1Bubble !== 4'd0) begin errors++; $display("[TB] FAIL reset_s1_bubble got %0d want 0", s1Bubble); end
        checks++; if (s1OutData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL reset_s1_data got %h want deadbeef", s1OutData); end
        checks++; if (s1InReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_s1_inready got %b want 1", s1InReady); end
        checks++; if (s0InReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_s0_inready got %b want 1", s0InReady); end
        checks++; if (s0OutData !== 32'h0) begin errors++; $display("[TB] FAIL reset_s0_data got %h want 0", s0OutData); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1;
            inData  = vals[i];
            tick();
            checks++; if (s1OutData !== vals[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, s1OutData, vals[i]); end
            checks++; if (s1Occ !== 2'd1) begin errors++; $display("[TB] FAIL b2b_occ[%0d] got %0d want 1", i, s1Occ); end
        end
        inValid = 1'b0;
        tick();
        checks++; if (s1OutValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain_valid got %b want 0", s1OutValid); end
        checks++; if (s1Bubble !== 4'd1) begin errors++; $display("[TB] FAIL b2b_bubble got %0d want 1", s1Bubble); end
        outReady = 1'b0;
    endtask

    task automatic test_stall_skid1();
        inValid = 1'b1;
        inData  = 32'hA;
        tick();
        inData = 32'hB;
        tick();
        inValid = 1'b0;
        checks++; if (s1Occ !== 2'd2) begin errors++; $display("[TB] FAIL stall1_occ got %0d want 2", s1Occ); end
        checks++; if (s1InReady !== 1'b0) begin errors++; $display("[TB] FAIL stall1_inready got %b want 0", s1InReady); end
        checks++; if (s1OutData !== 32'hA) begin errors++; $display("[TB] FAIL stall1_data got %h want a", s1OutData); end
        tick();
        checks++; if (s1OutData !== 32'hA || s1OutValid !== 1'b1) begin errors++; $display("[TB] FAIL stall1_hold got %h/%b want a/1", s1OutData, s1OutValid); end
        outReady = 1'b1;
        tick();
        checks++; if (s1OutData !== 32'hB) begin errors++; $display("[TB] FAIL stall1_second got %h want b", s1OutData); end
        checks++; if (s1InReady !== 1'b1) begin errors++; $display("[TB] FAIL stall1_inready_back got %b want 1", s1InReady); end
        checks++; if (s1Occ !== 2'd1) begin errors++; $display("[TB] FAIL stall1_occ_one got %0d want 1", s1Occ); end
        tick();
        checks++; if (s1OutValid !== 1'b0) begin errors++; $display("[TB] FAIL stall1_empty got %b want 0", s1OutValid); end
        outReady = 1'b0;
    endtask

    task automatic test_stall_skid0();
        inValid = 1'b1;
        inData  = 32'hA;
        tick();
        inData = 32'hB;
        #1;
        checks++; if (s0InReady !== 1'b0) begin errors++; $display("[TB] FAIL stall0_inready got %b want 0", s0InReady); end
        tick();
        inValid = 1'b0;
        checks++; if (s0OutData !== 32'hA || s0Occ !== 2'd1) begin errors++; $display("[TB] FAIL stall0_hold got %h/%0d want a/1", s0OutData, s0Occ); end
        outReady = 1'b1;
        #1;
        checks++; if (s0InReady !== 1'b1) begin errors++; $display("[TB] FAIL stall0_comb_ready got %b want 1", s0InReady); end
        tick();
        checks++; if (s0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL stall0_no_b got %b want 0", s0OutValid); end
        checks++; if (s1OutData !== 32'hB) begin errors++; $display("[TB] FAIL stall0_s1_b got %h want b", s1OutData); end
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_flush();
        inValid = 1'b1;
        inData  = 32'h5;
        tick();
        inData = 32'h6;
        tick();
        checks++; if (s1Occ !== 2'd2) begin errors++; $display("[TB] FAIL flush_fill_occ got %0d want 2", s1Occ); end
        flush    = 1'b1;
        inData   = 32'h7;
        outReady = 1'b1;
        #1;
        checks++; if (s1InReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_s1_inready got %b want 0", s1InReady); end
        checks++; if (s0InReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_s0_inready got %b want 0", s0InReady); end
        tick();
        checks++; if (s1Occ !== 2'd0 || s1OutValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_s1_state got %0d/%b want 0/0", s1Occ, s1OutValid); end
        checks++; if (s1OutData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL flush_s1_data got %h want deadbeef", s1OutData); end
        checks++; if (s0OutValid !== 1'b0 || s0OutData !== 32'h0) begin errors++; $display("[TB] FAIL flush_s0_state got %b/%h want 0/0", s0OutValid, s0OutData); end
        flush   = 1'b0;
        inValid = 1'b0;
        #1;
        checks++; if (s1InReady !== 1'b1) begin errors++; $display("[TB] FAIL flush_s1_ready_back got %b want 1", s1InReady); end
        outReady = 1'b0;
    endtask

    task automatic test_bubble();
        bubbleClr = 1'b1;
        tick();
        bubbleClr = 1'b0;
        checks++; if (s1Bubble !== 4'd0) begin errors++; $display("[TB] FAIL bubble_clr0 got %0d want 0", s1Bubble); end
        outReady = 1'b1;
        repeat (10) tick();
        checks++; if (s1Bubble !== 4'd10) begin errors++; $display("[TB] FAIL bubble_ten got %0d want 10", s1Bubble); end
        repeat (10) tick();
        checks++; if (s1Bubble !== 4'd15) begin errors++; $display("[TB] FAIL bubble_sat got %0d want 15", s1Bubble); end
        bubbleClr = 1'b1;
        tick();
        bubbleClr = 1'b0;
        checks++; if (s1Bubble !== 4'd0) begin errors++; $display("[TB] FAIL bubble_clr_prio got %0d want 0", s1Bubble); end
        outReady = 1'b0;
    endtask

    task automatic test_async_reset();
        outReady = 1'b1;
        repeat (2) tick();
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 32'h42;
        tick();
        inValid = 1'b0;
        checks++; if (s1Occ !== 2'd1 || s1Bubble !== 4'd2) begin errors++; $display("[TB] FAIL arst_pre got %0d/%0d want 1/2", s1Occ, s1Bubble); end
        #2 rst = 1'b1;
        #1;
        checks++; if (s1OutValid !== 1'b0 || s1Occ !== 2'd0) begin errors++; $display("[TB] FAIL arst_state got %b/%0d want 0/0", s1OutValid, s1Occ); end
        checks++; if (s1Bubble !== 4'd0) begin errors++; $display("[TB] FAIL arst_bubble got %0d want 0", s1Bubble); end
        checks++; if (s1OutData !== 32'hDEADBEEF || s1InReady !== 1'b1) begin errors++; $display("[TB] FAIL arst_data got %h/%b want deadbeef/1", s1OutData, s1InReady); end
        checks++; if (s0OutValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_s0_valid got %b want 0", s0OutValid); end
        #2 rst = 1'b0;
        inValid = 1'b1;
        inData  = 32'h99;
        #1;
        checks++; if (s1OutValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_post_idle got %b want 0", s1OutValid); end
        tick();
        inValid = 1'b0;
        checks++; if (s1OutValid !== 1'b1 || s1OutData !== 32'h99) begin errors++; $display("[TB] FAIL arst_first got %b/%h want 1/99", s1OutValid, s1OutData); end
        outReady = 1'b1;
        repeat (2) tick();
        outReady = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        inValid   = 1'b0;
        inData    = 32'h0;
        outReady  = 1'b0;
        bubbleClr = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall_skid1();
        test_stall_skid0();
        test_flush();
        test_bubble();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
